tone_voice_bank: RTL



---
 rtl/tone_voice_bank.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tone_voice_bank.sv
// tone_voice_bank
//   Multi-channel square-wave tone generator. Each of CHANNELS voices decodes
//   a 3-bit note code plus a 2-bit octave up-shift into a half-period (in clk
//   cycles, tuned for 12 MHz). The voice then produces a square wave that
//   starts and stops only on waveform boundaries, so every high pulse is
//   exactly half_q cycles long.
//
//   Optional feature macro: TONE_BANK_MIX_EN
//     defined   : mix_out = registered popcount of wave_out (1-cycle latency)
//     undefined : mix_out is tied to 0
//
// Ports
//   clk      in   1            system clock
//   rst      in   1            synchronous active-high reset
//   note     in   3*CHANNELS   note code, channel i at [3i+2:3i]
//   octave   in   2*CHANNELS   octave up-shift, channel i at [2i+1:2i]
//   gate     in   CHANNELS     per-channel key-on level
//   wave_out out  CHANNELS     per-channel square wave
//   active   out  CHANNELS     channel is in RUN or RELEASE
//   mix_out  out  clog2(CHANNELS+1)  count of high waves, previous cycle
//
// Handshake: there is no valid/ready pair; gate is a level sampled every
// clock, and wave_out/active/mix_out are valid every cycle after reset.
module tone_voice_bank #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [3*CHANNELS-1:0]             note,
   input  logic [2*CHANNELS-1:0]             octave,
   input  logic [CHANNELS-1:0]               gate,
   output logic [CHANNELS-1:0]               wave_out,
   output logic [CHANNELS-1:0]               active,
   output logic [$clog2(CHANNELS+1)-1:0]     mix_out
);

   localparam int MIX_W = $clog2(CHANNELS+1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      RELEASE = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] decode(input logic [2:0] n,
                                               input logic [1:0] o);
      logic [CNT_W-1:0] base;
      case (n)
         3'b000:  base = CNT_W'(22940); // C4
         3'b001:  base = CNT_W'(20434); // D4
         3'b011:  base = CNT_W'(18204); // E4
         3'b100:  base = CNT_W'(17190); // F4
         3'b110:  base = CNT_W'(15306); // G4
         3'b101:  base = CNT_W'(13636); // A4
         3'b010:  base = CNT_W'(12148); // B4
         default: base = CNT_W'(11471); // C5 (3'b111)
      endcase
      return base >> o;
   endfunction

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_t           state, state_n;
      logic [CNT_W-1:0] cnt, cnt_n;
      logic [CNT_W-1:0] half_q, half_n;
      logic             wave, wave_n;
      logic [CNT_W-1:0] half_dec;
      logic             at_end;

      assign half_dec = decode(note[3*i +: 3], octave[2*i +: 2]);
      assign at_end   = (cnt == half_q - CNT_W'(1));

      always_ff @(posedge clk) begin
         if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            half_q <= '0;
            wave   <= 1'b0;
         end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            half_q <= half_n;
            wave   <= wave_n;
         end
      end

      always_comb begin
         state_n = state;
         cnt_n   = cnt;
         half_n  = half_q;
         wave_n  = wave;
         case (state)
            IDLE: begin
               cnt_n  = '0;
               wave_n = 1'b0;
               if (gate[i]) begin
                  state_n = RUN;
                  wave_n  = 1'b1;
                  half_n  = half_dec;
               end
            end
            RUN, RELEASE: begin
               if (gate[i]) begin
                  // Re-gating out of RELEASE simply resumes RUN counting, so
                  // the waveform carries on without a hiccup.
                  state_n = RUN;
                  if (at_end) begin
                     cnt_n  = '0;
                     wave_n = ~wave;
                     // Pitch is only picked up at a rising edge (period start).
                     if (!wave) half_n = half_dec;
                  end else begin
                     cnt_n = cnt + CNT_W'(1);
                  end
               end else if (!wave) begin
                  // Key-off during the low phase: stop right away.
                  state_n = IDLE;
                  cnt_n   = '0;
               end else if (at_end) begin
                  // High phase of the released note completes.
                  state_n = IDLE;
                  wave_n  = 1'b0;
                  cnt_n   = '0;
               end else begin
                  state_n = RELEASE;
                  cnt_n   = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               wave_n  = 1'b0;
            end
         endcase
      end

      assign wave_out[i] = wave;
      assign active[i]   = (state != IDLE);
   end

`ifdef TONE_BANK_MIX_EN
   logic [MIX_W-1:0] pop;
   logic [MIX_W-1:0] mix_q;

   always_comb begin
      pop = '0;
      for (int k = 0; k < CHANNELS; k++) pop = pop + MIX_W'(wave_out[k]);
   end

   always_ff @(posedge clk) begin
      if (rst) mix_q <= '0;
      else     mix_q <= pop;
   end

   assign mix_out = mix_q;
`else
   assign mix_out = '0;
`endif

endmodule
